// File: rtl/wb_cmd_master.sv
// Executes one 78-bit command word as a single Wishbone classic cycle and
// returns status/read data on a valid/ready response port; "sync" ext commands complete locally.
module wb_cmd_master #(
  parameter int          TIMEOUT  = 255,
  parameter int          TO_W     = 8,
  parameter logic [7:0]  EXT_SYNC = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [77:0] cmd_in,
  output logic        cmd_taken,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_datw,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic [31:0] wb_datr,
  output logic        rsp_val,
  input  logic        rsp_rdy,
  output logic        rsp_we,
  output logic        rsp_err,
  output logic        rsp_tmo,
  output logic [31:0] rsp_dat,
  output logic [7:0]  rsp_ext
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]      r_state;
  logic            r_we;
  logic [3:0]      r_sel;
  logic [31:0]     r_adr;
  logic [31:0]     r_datw;
  logic [7:0]      r_ext;
  logic [TO_W-1:0] r_cnt;
  logic            r_rsp_err;
  logic            r_rsp_tmo;
  logic [31:0]     r_rsp_dat;

  logic            w_take;
  logic            w_in_bus;

  assign w_take   = (r_state == S_IDLE) & cmd_in[77];
  assign w_in_bus = (r_state == S_BUS);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_adr     <= '0;
      r_datw    <= '0;
      r_ext     <= '0;
      r_cnt     <= '0;
      r_rsp_err <= 1'b0;
      r_rsp_tmo <= 1'b0;
      r_rsp_dat <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_we      <= cmd_in[76];
            r_sel     <= cmd_in[75:72];
            r_adr     <= cmd_in[71:40];
            r_datw    <= cmd_in[39:8];
            r_ext     <= cmd_in[7:0];
            r_cnt     <= '0;
            r_rsp_err <= 1'b0;
            r_rsp_tmo <= 1'b0;
            r_rsp_dat <= '0;
            r_state   <= (cmd_in[7:0] == EXT_SYNC) ? S_RSP : S_BUS;
          end
        end
        S_BUS: begin
          // err beats ack, and either beats a timeout landing in the same cycle
          if (wb_err) begin
            r_rsp_err <= 1'b1;
            r_rsp_dat <= '0;
            r_state   <= S_RSP;
          end else if (wb_ack) begin
            r_rsp_dat <= r_we ? 32'd0 : wb_datr;
            r_state   <= S_RSP;
          end else if (r_cnt == CNT_LAST) begin
            r_rsp_tmo <= 1'b1;
            r_rsp_dat <= '0;
            r_state   <= S_RSP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RSP: begin
          if (rsp_rdy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_taken = w_take;
  assign wb_cyc    = w_in_bus;
  assign wb_stb    = w_in_bus;
  assign wb_we     = r_we;
  assign wb_sel    = r_sel;
  assign wb_adr    = r_adr;
  assign wb_datw   = r_datw;

  assign rsp_val   = (r_state == S_RSP);
  assign rsp_we    = r_we;
  assign rsp_err   = r_rsp_err;
  assign rsp_tmo   = r_rsp_tmo;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_ext   = r_ext;

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Consumes one generic 78-bit command word from the command-interface stage and executes it as a single Wishbone classic cycle on one external bus.
- Returns read data and status to the core side through a valid/ready response port.
- One instance per command output bus: one for a single-bus configuration, two for a dual-bus configuration.
- Handles the "sync" extended command locally, with no bus cycle.

Parameters:
- TIMEOUT, 255: bus cycles to wait for ack/err before abandoning the cycle. Legal range 1 to 2^TO_W-1.
- TO_W, 8: width of the timeout counter.
- EXT_SYNC, 8'h10: ext_cmd code completed locally, with no bus activity.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-low
- cmd_in  in  78  command word. [77] valid, [76] we, [75:72] sel, [71:40] adr, [39:8] write data, [7:0] ext_cmd
- cmd_taken  out  1  command accepted this cycle
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_we  out  1  Wishbone write enable
- wb_sel  out  4  Wishbone byte selects
- wb_adr  out  32  Wishbone address
- wb_datw  out  32  Wishbone write data
- wb_ack  in  1  Wishbone acknowledge
- wb_err  in  1  Wishbone error
- wb_datr  in  32  Wishbone read data
- rsp_val  out  1  response valid
- rsp_rdy  in  1  response accepted
- rsp_we  out  1  response is for a write
- rsp_err  out  1  bus error
- rsp_tmo  out  1  timeout
- rsp_dat  out  32  read data
- rsp_ext  out  8  ext_cmd of the command being answered

Behaviour:
- All state updates on the rising edge of clk.
- rst low at an edge forces:
  - state to IDLE;
  - wb_cyc, wb_stb, rsp_val low;
  - all other registered outputs to 0.
- Reset mid-cycle drops wb_cyc at that edge, with no response. A reset mid-response discards the pending response.
- State machine: IDLE, BUS, RSP.
- IDLE:
  - cmd_taken = (state==IDLE) & cmd_in[77]. This is combinational from the state register, so it is high in the capture cycle only.
  - On an edge with cmd_taken high, capture we, sel, adr, datw and ext into the command register.
  - If ext == EXT_SYNC: go to RSP with rsp_err=0, rsp_tmo=0, rsp_dat=0. No bus cycle is issued.
  - Otherwise go to BUS and clear the timeout counter.
  - cmd_taken is never high outside IDLE. The upstream stage holds cmd_in until taken.
- BUS:
  - wb_cyc = wb_stb = 1.
  - wb_we, wb_sel, wb_adr, wb_datw come from the command register and are stable for the whole cycle.
  - Earliest ack is sampled in the first BUS cycle, so the minimum command-to-response latency is 2 edges.
  - wb_ack: go to RSP. rsp_dat = wb_datr for reads, 0 for writes.
  - wb_err: go to RSP with rsp_err=1 and rsp_dat=0. If wb_ack and wb_err are both high, err wins.
  - Timeout counter increments each BUS cycle without ack/err. When the count reaches TIMEOUT-1 and no ack/err is present, the next edge goes to RSP with rsp_tmo=1, rsp_dat=0, and wb_cyc/wb_stb drop.
  - ack/err in the same cycle as the timeout: ack/err wins and rsp_tmo=0.
  - wb_cyc is low in the cycle after leaving BUS, so there are no back-to-back cycles without an idle. Minimum command spacing is 3 cycles.
- RSP:
  - rsp_val=1; rsp_we, rsp_ext, rsp_err, rsp_tmo, rsp_dat are held stable.
  - On an edge with rsp_rdy high: rsp_val drops and the block returns to IDLE.
  - A new cmd_in is not taken in that same cycle; cmd_taken first rises in the following IDLE cycle.
  - rsp_rdy held low stalls indefinitely. wb_cyc stays low and no command is taken.
- rsp_err and rsp_tmo are never both 1.
- wb_ack/wb_err seen outside BUS are ignored.

Test Plan:
- Read: cmd valid, we=0, adr=32'h0000_1000, sel=4'hF; slave acks in the 3rd BUS cycle with datr=32'hDEADBEEF.
  -> cmd_taken pulses 1 cycle; wb_adr=32'h1000 for exactly 3 cycles; rsp_val=1 with rsp_dat=32'hDEADBEEF, rsp_we=0, rsp_err=0, rsp_tmo=0.
- Write: we=1, sel=4'h3, adr=32'h2004, data=32'h1234_5678; ack immediate.
  -> wb_datw=32'h12345678, wb_sel=4'h3 for 1 cycle; rsp_we=1, rsp_dat=0.
- Timeout: TIMEOUT=4, slave never responds.
  -> wb_cyc high exactly 4 cycles, then low; rsp_tmo=1, rsp_err=0.
- Error and simultaneity:
  - ack and err both high -> rsp_err=1.
  - Separate run with TIMEOUT=4: ack arrives in the 4th BUS cycle -> rsp_tmo=0, data returned.
- Sync and backpressure: ext=8'h10 -> wb_cyc never rises; rsp_val after 1 edge. Hold rsp_rdy=0 for 10 cycles -> rsp_val and rsp_ext=8'h10 stable; cmd_taken stays 0 with a second command waiting.
- Reset mid-cycle: rst low during BUS -> wb_cyc=0 and rsp_val=0 after that edge. After release, a new command completes normally.
